mem_bus_arbiter: RTL and testbench

- Sits between the core's two memory clients and a single external memory port.
- Clients: the fetch stage (read-only) and the memory stage (load/store).
- Replaces the dual-port RAM helper path with one shared, variable-latency valid/ready bus, one transaction outstanding at a time.
- Data-side requests have fixed priority over instruction fetch; a fetch flush discards an in-flight fetch response without breaking the bus handshake.

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_arb_sel.sv | 15 +
 rtl/mem_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the two-client memory bus arbiter: FSM states, owner IDs,
// word-alignment mask and a width helper macro for bus-sized registers.
`ifndef MEM_ARB_REG_BUS
`define MEM_ARB_REG_BUS(W) logic [(W)-1:0]
`endif

package mem_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_ME = 1'b1;

    // Bus addresses are always 8-byte aligned; truncated to ADDR_W at use.
    localparam logic [63:0] ALIGN_MASK = ~64'h7;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant selection: data side has fixed priority, a fetch
// is only granted when no flush is asserted in the same cycle.
module mem_arb_sel (
    input  logic idle,
    input  logic if_req_valid,
    input  logic if_flush,
    input  logic me_req_valid,
    output logic if_grant,
    output logic me_grant
);

    assign me_grant = idle && me_req_valid;
    assign if_grant = idle && !me_req_valid && if_req_valid && !if_flush;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and load/store clients onto one valid/ready memory bus,
// one transaction in flight, with fetch-flush response dropping.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              me_req_valid,
    output logic              me_req_ready,
    input  logic              me_we,
    input  logic [ADDR_W-1:0] me_addr,
    input  logic [DATA_W-1:0] me_wdata,
    input  logic [STRB_W-1:0] me_wstrb,
    output logic              me_resp_valid,
    output logic [DATA_W-1:0] me_rdata,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    input  logic              bus_resp_valid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(ALIGN_MASK);

    logic [1:0]               state_reg;
    logic [1:0]               state_next;
    logic                     owner_reg;
    logic                     we_reg;
    logic                     drop_reg;
    `MEM_ARB_REG_BUS(ADDR_W)  addr_reg;
    `MEM_ARB_REG_BUS(DATA_W)  wdata_reg;
    `MEM_ARB_REG_BUS(DATA_W)  if_rdata_reg;
    `MEM_ARB_REG_BUS(DATA_W)  me_rdata_reg;
    logic [STRB_W-1:0]        wstrb_reg;

    logic idle;
    logic if_grant;
    logic me_grant;
    logic in_done;

    // Gating with !rst keeps every handshake output quiet while reset is held.
    assign idle = !rst && (state_reg == ST_IDLE);

    mem_arb_sel u_sel (
        .idle         (idle),
        .if_req_valid (if_req_valid),
        .if_flush     (if_flush),
        .me_req_valid (me_req_valid),
        .if_grant     (if_grant),
        .me_grant     (me_grant)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (me_grant || if_grant) state_next = ST_REQ;
            ST_REQ:  if (bus_req_ready)        state_next = ST_WAIT;
            ST_WAIT: if (bus_resp_valid)       state_next = ST_DONE;
            ST_DONE:                           state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= OWN_IF;
            we_reg       <= 1'b0;
            drop_reg     <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            if_rdata_reg <= '0;
            me_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (me_grant) begin
                owner_reg <= OWN_ME;
                we_reg    <= me_we;
                addr_reg  <= me_addr;
                wdata_reg <= me_wdata;
                wstrb_reg <= me_wstrb;
            end else if (if_grant) begin
                owner_reg <= OWN_IF;
                we_reg    <= 1'b0;
                addr_reg  <= if_addr;
                wdata_reg <= '0;
                wstrb_reg <= '0;
            end

            if (state_reg == ST_WAIT && bus_resp_valid) begin
                if (owner_reg == OWN_ME) begin
                    me_rdata_reg <= we_reg ? '0 : bus_rdata;
                end else begin
                    if_rdata_reg <= bus_rdata;
                end
            end

            // A flush during DONE is handled combinationally on the pulse itself.
            if (state_reg == ST_DONE) begin
                drop_reg <= 1'b0;
            end else if ((state_reg == ST_REQ || state_reg == ST_WAIT) &&
                         owner_reg == OWN_IF && if_flush) begin
                drop_reg <= 1'b1;
            end
        end
    end

    assign in_done = !rst && (state_reg == ST_DONE);

    assign if_req_ready  = if_grant;
    assign me_req_ready  = me_grant;
    assign bus_req_valid = !rst && (state_reg == ST_REQ);
    assign bus_we        = we_reg;
    assign bus_addr      = addr_reg & ADDR_MASK;
    assign bus_wdata     = wdata_reg;
    assign bus_wstrb     = wstrb_reg;
    assign me_resp_valid = in_done && (owner_reg == OWN_ME);
    assign if_resp_valid = in_done && (owner_reg == OWN_IF) && !drop_reg && !if_flush;
    assign if_rdata      = if_rdata_reg;
    assign me_rdata      = me_rdata_reg;
    assign busy          = !rst && (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, random
// transactions against a timeline reference model, and reset corner cases.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_flush;
    logic        if_resp_valid;
    logic [63:0] if_rdata;
    logic        me_req_valid;
    logic        me_req_ready;
    logic        me_we;
    logic [63:0] me_addr;
    logic [63:0] me_wdata;
    logic [7:0]  me_wstrb;
    logic        me_resp_valid;
    logic [63:0] me_rdata;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic [63:0] bus_rdata;
    logic        busy;

    mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .STRB_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_flush       (if_flush),
        .if_resp_valid  (if_resp_valid),
        .if_rdata       (if_rdata),
        .me_req_valid   (me_req_valid),
        .me_req_ready   (me_req_ready),
        .me_we          (me_we),
        .me_addr        (me_addr),
        .me_wdata       (me_wdata),
        .me_wstrb       (me_wstrb),
        .me_resp_valid  (me_resp_valid),
        .me_rdata       (me_rdata),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_resp_valid (bus_resp_valid),
        .bus_rdata      (bus_rdata),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          me_v;
        bit          if_v;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] rdata;
        int          req_lat;
        int          resp_lat;
        int          flush_cyc;
        bit          flush_acc;
        bit          spur;
        bit          exp_me;
        bit          exp_if;
        bit          exp_if_pulse;
        int          exp_total;
        logic [63:0] exp_addr;
        logic [63:0] exp_rdata;
        bit          exp_we;
        logic [7:0]  exp_wstrb;
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_me_rdata = 64'h0;
    txn_t        vec[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: priority, timeline and data rules taken straight from the behaviour description.
    function automatic txn_t model(input txn_t t);
        txn_t r = t;
        r.exp_me       = t.me_v;
        r.exp_if       = !t.me_v && t.if_v && !t.flush_acc;
        r.exp_total    = t.req_lat + t.resp_lat + 3;
        r.exp_addr     = t.addr & ~64'h7;
        r.exp_we       = r.exp_me && t.we;
        r.exp_wstrb    = r.exp_me ? t.wstrb : 8'h00;
        r.exp_rdata    = r.exp_we ? 64'h0 : t.rdata;
        r.exp_if_pulse = r.exp_if && !(t.flush_cyc >= 1 && t.flush_cyc <= r.exp_total);
        return r;
    endfunction

    function automatic txn_t mk(input bit me_v, input bit if_v, input bit we,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [7:0] wstrb, input logic [63:0] rdata,
                                input int rl, input int pl, input int fc, input bit fa);
        txn_t t;
        t.me_v = me_v; t.if_v = if_v; t.we = we; t.addr = addr; t.wdata = wdata;
        t.wstrb = wstrb; t.rdata = rdata; t.req_lat = rl; t.resp_lat = pl;
        t.flush_cyc = fc; t.flush_acc = fa; t.spur = 1'b0;
        return model(t);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_me_ready"},  me_req_ready,  0);
        chk({tag, "_if_ready"},  if_req_ready,  0);
        chk({tag, "_bus_valid"}, bus_req_valid, 0);
        chk({tag, "_busy"},      busy,          0);
        chk({tag, "_me_resp"},   me_resp_valid, 0);
        chk({tag, "_if_resp"},   if_resp_valid, 0);
        chk({tag, "_bus_addr"},  bus_addr,      0);
        chk({tag, "_bus_we"},    bus_we,        0);
        chk({tag, "_bus_wdata"}, bus_wdata,     0);
        chk({tag, "_bus_wstrb"}, bus_wstrb,     0);
        chk({tag, "_if_rdata"},  if_rdata,      0);
        chk({tag, "_me_rdata"},  me_rdata,      0);
    endtask

    task automatic run_txn(input int idx, input txn_t t);
        int total;
        bit in_req;
        total = t.exp_total;
        $display("txn %0d: me=%0d if=%0d we=%0d addr=%h rl=%0d pl=%0d flush=%0d/%0d",
                 idx, t.me_v, t.if_v, t.we, t.addr, t.req_lat, t.resp_lat, t.flush_acc, t.flush_cyc);
        @(negedge clk);
        me_req_valid = t.me_v; me_we = t.we; me_addr = t.addr;
        me_wdata = t.wdata; me_wstrb = t.wstrb;
        if_req_valid = t.if_v; if_addr = t.addr; if_flush = t.flush_acc;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = {$urandom, $urandom};
        #1;
        chk("idle_busy", busy, 0);
        chk("me_req_ready", me_req_ready, t.exp_me);
        chk("if_req_ready", if_req_ready, t.exp_if);
        chk("me_rdata_hold", me_rdata, last_me_rdata);
        @(posedge clk);
        if (!t.exp_me && !t.exp_if) begin
            @(negedge clk);
            me_req_valid = 1'b0; if_req_valid = 1'b0; if_flush = 1'b0;
            #1;
            chk("noacc_bus_valid", bus_req_valid, 0);
            chk("noacc_busy", busy, 0);
            @(posedge clk);
            return;
        end
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            me_req_valid = 1'b0;
            if_req_valid = t.exp_me && t.if_v;
            if_flush = (c == t.flush_cyc);
            in_req = (c <= t.req_lat + 1);
            bus_req_ready = (c == t.req_lat + 1);
            bus_resp_valid = (c == total - 1) || (t.spur && in_req);
            bus_rdata = (c == total - 1) ? t.rdata : {$urandom, $urandom};
            #1;
            chk("bus_req_valid", bus_req_valid, in_req);
            if (in_req) begin
                chk("bus_addr", bus_addr, t.exp_addr);
                chk("bus_we", bus_we, t.exp_we);
                chk("bus_wstrb", bus_wstrb, t.exp_wstrb);
                if (t.exp_me) chk("bus_wdata", bus_wdata, t.wdata);
            end
            chk("busy", busy, 1);
            chk("me_ready_busy", me_req_ready, 0);
            chk("if_ready_busy", if_req_ready, 0);
            chk("me_resp_valid", me_resp_valid, (c == total) && t.exp_me);
            chk("if_resp_valid", if_resp_valid, (c == total) && t.exp_if_pulse);
            if (c == total && t.exp_me) begin
                chk("me_rdata", me_rdata, t.exp_rdata);
                last_me_rdata = t.exp_rdata;
            end
            if (c == total && t.exp_if_pulse) chk("if_rdata", if_rdata, t.exp_rdata);
            @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        rst = 1'b1;
        if_req_valid = 1'b1; if_addr = 64'h0; if_flush = 1'b0;
        me_req_valid = 1'b1; me_we = 1'b0; me_addr = 64'h0; me_wdata = 64'h0; me_wstrb = 8'h0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = 64'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0; if_req_valid = 1'b0; me_req_valid = 1'b0;

        vec[0] = mk(1, 0, 0, 64'h8000_0014, 64'h0, 8'h00, 64'h1122334455667788, 0, 0, 0, 0);
        vec[1] = mk(1, 1, 1, 64'h0000_1003, 64'h0102030405060708, 8'h0F, 64'hDEAD, 0, 0, 0, 0);
        vec[2] = mk(0, 1, 0, 64'h8000_0044, 64'h0, 8'h00, 64'hCAFEF00D12345678, 1, 2, 0, 0);
        vec[3] = mk(1, 0, 1, 64'h0000_2008, 64'hAABBCCDD00000000, 8'hF0, 64'h5555, 5, 0, 0, 0);
        vec[4] = mk(0, 1, 0, 64'h8000_0000, 64'h0, 8'h00, 64'h9999, 0, 1, 2, 0);
        vec[5] = mk(0, 1, 0, 64'h8000_0008, 64'h0, 8'h00, 64'h0BADBEEF0BADBEEF, 0, 0, 0, 0);
        vec[6] = mk(0, 1, 0, 64'h8000_0010, 64'h0, 8'h00, 64'h7777, 0, 0, 0, 1);
        vec[7] = mk(1, 0, 0, 64'h0000_0040, 64'h0, 8'hFF, 64'h123456789ABCDEF0, 0, 1, 2, 0);
        vec[8] = mk(0, 1, 0, 64'h8000_0018, 64'h0, 8'h00, 64'h4444, 0, 1, 4, 0);
        for (int i = 0; i < 9; i++) run_txn(i, vec[i]);

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            t.me_v = (r < 5);
            t.if_v = (r >= 3);
            t.we = $urandom_range(0, 1) == 1;
            t.addr = {$urandom, $urandom};
            t.wdata = {$urandom, $urandom};
            t.wstrb = 8'($urandom);
            t.rdata = {$urandom, $urandom};
            t.req_lat = $urandom_range(0, 3);
            t.resp_lat = $urandom_range(0, 3);
            t.flush_acc = ($urandom_range(0, 5) == 0);
            t.spur = $urandom_range(0, 1) == 1;
            t.flush_cyc = ($urandom_range(0, 2) == 0) ?
                          $urandom_range(1, t.req_lat + t.resp_lat + 3) : 0;
            t = model(t);
            run_txn(100 + i, t);
        end

        // Reset while waiting for a read response, then a late response.
        $display("txn reset_mid_wait");
        @(negedge clk);
        me_req_valid = 1'b0; if_req_valid = 1'b1; if_addr = 64'h3000; if_flush = 1'b0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        #1;
        chk("rw_if_ready", if_req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if_req_valid = 1'b0; bus_req_ready = 1'b1;
        #1;
        chk("rw_bus_valid", bus_req_valid, 1);
        @(posedge clk);
        @(negedge clk);
        bus_req_ready = 1'b0; rst = 1'b1;
        #1;
        chk("rw_no_resp_in_rst", if_resp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 64'hFEEDFACEFEEDFACE;
        #1;
        check_all_zero("rw_after");
        last_me_rdata = 64'h0;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus_resp_valid = 1'b0;
            #1;
            chk("rw_late_if_resp", if_resp_valid, 0);
            chk("rw_late_me_resp", me_resp_valid, 0);
            chk("rw_late_busy", busy, 0);
            @(posedge clk);
        end
        run_txn(200, vec[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
